// File: rtl/quad_enc_gen_if.sv
// Command channel of quad_enc_gen: move request (steps, direction, edge period)
// carried over a valid/ready handshake.
interface quad_enc_gen_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_enc_gen.sv
// Quadrature encoder signal generator: emits A/B edges for queued moves and
// tracks a signed position. Define QUAD_ENC_GEN_INDEX_EN to add the enc_z index output.
module quad_enc_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16,
  parameter int POS_W = 24
`ifdef QUAD_ENC_GEN_INDEX_EN
  , parameter int INDEX_LOG2 = 12
`endif
) (
  input  logic             clk,
  input  logic             reset,
  quad_enc_gen_if.slave    cmd,
  input  logic             cmd_abort,
  input  logic             pos_clear,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position
`ifdef QUAD_ENC_GEN_INDEX_EN
  , output logic           enc_z
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_eff;
  logic             dir_q;
  logic             edge_due;
  logic [POS_W-1:0] pos_next;

  // A/B/Z are registered from pos_next so they always agree with position.
  always_comb begin
    period_eff = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
    edge_due   = (state == RUN) && (timer == '0);
    pos_next   = position;
    if ((state == IDLE) && pos_clear) begin
      pos_next = '0;
    end else if (edge_due) begin
      pos_next = dir_q ? (position + POS_W'(1)) : (position - POS_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rem           <= '0;
      timer         <= '0;
      period_q      <= '0;
      dir_q         <= 1'b0;
      position      <= '0;
      enc_a         <= 1'b0;
      enc_b         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      cmd.cmd_ready <= 1'b1;
`ifdef QUAD_ENC_GEN_INDEX_EN
      enc_z         <= 1'b0;
`endif
    end else begin
      position <= pos_next;
      enc_a    <= pos_next[1] ^ pos_next[0];
      enc_b    <= pos_next[1];
`ifdef QUAD_ENC_GEN_INDEX_EN
      enc_z    <= (pos_next[INDEX_LOG2-1:0] == '0);
`endif
      done     <= 1'b0;
      aborted  <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            dir_q    <= cmd.cmd_dir;
            period_q <= period_eff;
            timer    <= period_eff - DIV_W'(1);
            rem      <= cmd.cmd_steps;
            if (cmd.cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state         <= RUN;
              busy          <= 1'b1;
              cmd.cmd_ready <= 1'b0;
            end
          end
        end

        RUN: begin
          // A due edge always goes out; the final edge wins over a same-cycle abort.
          if (edge_due) begin
            rem   <= rem - CNT_W'(1);
            timer <= period_q - DIV_W'(1);
            if (rem == CNT_W'(1)) begin
              state         <= IDLE;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b1;
              done          <= 1'b1;
            end else if (cmd_abort) begin
              state         <= IDLE;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b1;
              aborted       <= 1'b1;
            end
          end else if (cmd_abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            aborted       <= 1'b1;
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: a position model queues expected edges and
// done/aborted pulses with their cycle numbers; a negedge monitor pops and checks them.
module tb_quad_enc_gen;

  localparam int unsigned K_CHG   = 0;
  localparam int unsigned K_DONE  = 1;
  localparam int unsigned K_ABORT = 2;

  typedef struct {
    int unsigned kind;
    int unsigned cyc;
    logic [23:0] pos;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_abort;
  logic        pos_clear;
  logic        enc_a;
  logic        enc_b;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [23:0] position;
`ifdef QUAD_ENC_GEN_INDEX_EN
  logic        enc_z;
`endif

  quad_enc_gen_if #(.CNT_W(16), .DIV_W(16)) cif ();

  quad_enc_gen #(
    .CNT_W(16),
    .DIV_W(16),
    .POS_W(24)
`ifdef QUAD_ENC_GEN_INDEX_EN
    , .INDEX_LOG2(2)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cif),
    .cmd_abort(cmd_abort),
    .pos_clear(pos_clear),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .position (position)
`ifdef QUAD_ENC_GEN_INDEX_EN
    , .enc_z  (enc_z)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  ev_t         q[$];
  logic [23:0] mpos  = '0;
  logic        mon_hold = 1'b1;
  logic [23:0] prev_pos = '0;
  logic        prev_a   = 1'b0;
  logic        prev_b   = 1'b0;
  ev_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {A,B} for each value of position[1:0].
  function automatic logic [1:0] ab_of(input logic [23:0] p);
    logic [1:0] lo;
    lo = p[1:0];
    case (lo)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic void push_ev(input int unsigned k, input int unsigned c, input logic [23:0] p);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.pos  = p;
    q.push_back(e);
  endfunction

  function automatic void plan_cmd(input int unsigned t0, input int unsigned steps, input logic dir,
                                   input int unsigned period, input int unsigned abort_at, input logic clr);
    int unsigned p;
    if (clr && (mpos != '0)) begin
      mpos = '0;
      push_ev(K_CHG, t0, mpos);
    end
    p = (period == 0) ? 1 : period;
    if (steps == 0) begin
      push_ev(K_DONE, t0, mpos);
      return;
    end
    for (int unsigned k = 1; k <= steps; k++) begin
      if ((abort_at != 0) && (abort_at < k * p)) begin
        push_ev(K_ABORT, t0 + abort_at, mpos);
        return;
      end
      mpos = dir ? (mpos + 24'd1) : (mpos - 24'd1);
      push_ev(K_CHG, t0 + k * p, mpos);
      if (k == steps) begin
        push_ev(K_DONE, t0 + k * p, mpos);
        return;
      end
      if (abort_at == k * p) begin
        push_ev(K_ABORT, t0 + k * p, mpos);
        return;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!mon_hold && reset) begin
      if ((position !== prev_pos) || (enc_a !== prev_a) || (enc_b !== prev_b)) begin
        if ((q.size() != 0) && (q[0].kind == K_CHG)) begin
          mon_e = q.pop_front();
          check_eq("edge_cycle", cyc, mon_e.cyc);
          check_eq("edge_pos", position, {8'd0, mon_e.pos});
          check_eq("edge_ab", {30'd0, enc_a, enc_b}, {30'd0, ab_of(mon_e.pos)});
`ifdef QUAD_ENC_GEN_INDEX_EN
          check_eq("edge_z", enc_z, (mon_e.pos[1:0] == 2'b00));
`endif
        end else begin
          check_eq("spurious_chg", {6'd0, enc_a, enc_b, position}, {6'd0, prev_a, prev_b, prev_pos});
        end
      end
      if (done || aborted) check_eq("done_and_aborted", done & aborted, 1'b0);
      if (done) begin
        if ((q.size() != 0) && (q[0].kind == K_DONE)) begin
          mon_e = q.pop_front();
          check_eq("done_cycle", cyc, mon_e.cyc);
          check_eq("done_pos", position, {8'd0, mon_e.pos});
          check_eq("done_busy", busy, 1'b0);
          check_eq("done_ready", cif.cmd_ready, 1'b1);
        end else begin
          check_eq("spurious_done", done, 1'b0);
        end
      end
      if (aborted) begin
        if ((q.size() != 0) && (q[0].kind == K_ABORT)) begin
          mon_e = q.pop_front();
          check_eq("abort_cycle", cyc, mon_e.cyc);
          check_eq("abort_pos", position, {8'd0, mon_e.pos});
          check_eq("abort_busy", busy, 1'b0);
        end else begin
          check_eq("spurious_abort", aborted, 1'b0);
        end
      end
      prev_pos = position;
      prev_a   = enc_a;
      prev_b   = enc_b;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain", q.size(), 0);
  endtask

  task automatic send_cmd(input int unsigned steps, input logic dir, input int unsigned period,
                          input int unsigned abort_at, input logic clr, input logic clr_in_run);
    int unsigned t0;
    @(negedge clk);
    cif.cmd_valid  = 1'b1;
    cif.cmd_steps  = 16'(steps);
    cif.cmd_dir    = dir;
    cif.cmd_period = 16'(period);
    pos_clear      = clr;
    t0 = cyc + 1;
    plan_cmd(t0, steps, dir, period, abort_at, clr);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    pos_clear     = 1'b0;
    if (steps != 0) begin
      check_eq("run_busy", busy, 1'b1);
      check_eq("run_ready", cif.cmd_ready, 1'b0);
    end
    if (clr_in_run) begin
      pos_clear = 1'b1;
      @(posedge clk); #1;
      pos_clear = 1'b0;
    end
    if (abort_at != 0) begin
      while (cyc + 1 < t0 + abort_at) begin
        @(posedge clk); #1;
      end
      cmd_abort = 1'b1;
      @(posedge clk); #1;
      cmd_abort = 1'b0;
    end
    wait_drain();
  endtask

  task automatic do_clear();
    @(negedge clk);
    pos_clear = 1'b1;
    if (mpos != '0) begin
      mpos = '0;
      push_ev(K_CHG, cyc + 1, mpos);
    end
    @(posedge clk); #1;
    pos_clear = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    logic [23:0] start;
    reset          = 1'b0;
    cmd_abort      = 1'b0;
    pos_clear      = 1'b0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_steps  = '0;
    cif.cmd_dir    = 1'b0;
    cif.cmd_period = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", cif.cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_aborted", aborted, 1'b0);
    check_eq("rst_pos", position, 0);
    check_eq("rst_ab", {enc_a, enc_b}, 2'b00);
`ifdef QUAD_ENC_GEN_INDEX_EN
    check_eq("rst_z", enc_z, 1'b0);
`endif
    @(negedge clk);
    reset    = 1'b1;
    prev_pos = position;
    prev_a   = enc_a;
    prev_b   = enc_b;
    mon_hold = 1'b0;

    // forward move, with a pos_clear during RUN that must be ignored
    send_cmd(4, 1'b1, 3, 0, 1'b0, 1'b1);
    check_eq("fwd_pos", position, 24'd4);
    do_clear();

    // reverse move through zero with period 0
    send_cmd(2, 1'b0, 0, 0, 1'b0, 1'b0);
    check_eq("rev_wrap_pos", position, 24'hFFFFFE);

    // zero-step command with abort in IDLE, then a command accepted in its done cycle
    @(negedge clk);
    cif.cmd_valid  = 1'b1;
    cif.cmd_steps  = 16'd0;
    cif.cmd_dir    = 1'b1;
    cif.cmd_period = 16'd5;
    cmd_abort      = 1'b1;
    t0 = cyc + 1;
    plan_cmd(t0, 0, 1'b1, 5, 0, 1'b0);
    @(posedge clk); #1;
    cmd_abort      = 1'b0;
    cif.cmd_steps  = 16'd1;
    cif.cmd_period = 16'd2;
    plan_cmd(t0 + 1, 1, 1'b1, 2, 0, 1'b0);
    check_eq("b2b_ready", cif.cmd_ready, 1'b1);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    check_eq("b2b_busy", busy, 1'b1);
    wait_drain();
    check_eq("b2b_pos", position, 24'hFFFFFF);

    // abort between edges, starting from a cleared position
    send_cmd(10, 1'b1, 4, 9, 1'b1, 1'b0);
    check_eq("abort_final_pos", position, 24'd2);
    // abort coinciding with the final edge
    send_cmd(3, 1'b1, 2, 6, 1'b0, 1'b0);
    check_eq("abort_last_pos", position, 24'd5);
`ifdef QUAD_ENC_GEN_INDEX_EN
    check_eq("z_at_5", enc_z, 1'b0);
`endif
    do_clear();
`ifdef QUAD_ENC_GEN_INDEX_EN
    check_eq("z_after_clear", enc_z, 1'b1);
`endif
    check_eq("clear_pos", position, 0);
    send_cmd(8, 1'b1, 1, 0, 1'b0, 1'b0);
    check_eq("idx_run_pos", position, 24'd8);

    // reset in the middle of a move after three edges
    start = mpos;
    @(negedge clk);
    cif.cmd_valid  = 1'b1;
    cif.cmd_steps  = 16'd8;
    cif.cmd_dir    = 1'b1;
    cif.cmd_period = 16'd2;
    t0 = cyc + 1;
    plan_cmd(t0, 8, 1'b1, 2, 0, 1'b0);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    while (cyc < t0 + 7) begin
      @(posedge clk); #1;
    end
    check_eq("pre_reset_pos", position, start + 24'd3);
    mon_hold = 1'b1;
    q.delete();
    #1 reset = 1'b0;
    #1;
    check_eq("amid_rst_pos", position, 0);
    check_eq("amid_rst_ab", {enc_a, enc_b}, 2'b00);
    check_eq("amid_rst_busy", busy, 1'b0);
    check_eq("amid_rst_ready", cif.cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    mpos     = '0;
    prev_pos = position;
    prev_a   = enc_a;
    prev_b   = enc_b;
    mon_hold = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("post_rst_ready", cif.cmd_ready, 1'b1);
    check_eq("post_rst_pos", position, 0);

    send_cmd(2, 1'b0, 1, 0, 1'b0, 1'b0);
    check_eq("final_pos", position, 24'hFFFFFE);
    repeat (5) @(negedge clk);
    check_eq("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quad_enc_gen.md
Name: quad_enc_gen

Overview:
- Quadrature encoder signal generator: the transmit side of the enc_a/enc_b interface consumed by the encoder-input blocks.
- Accepts move commands (step count, direction, edge period) over a valid/ready handshake and emits A/B quadrature edges.
- Keeps a signed position counter.
- Used as a motor/encoder emulator that drives the encoder-input blocks in loopback and in demos.

Parameters:
CNT_W, 16, width of cmd_steps (edges per command)
DIV_W, 16, width of cmd_period (clk cycles per edge)
POS_W, 24, width of position counter (two's complement)
INDEX_LOG2, 12, log2 of counts per revolution for index output (optional feature only)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_steps  input  CNT_W  number of quadrature edges to emit
cmd_dir  input  1  1 = forward (A leads B), 0 = reverse
cmd_period  input  DIV_W  clk cycles between edges; 0 treated as 1
cmd_abort  input  1  stop current move
pos_clear  input  1  zero position (honoured in IDLE only)
enc_a  output  1  quadrature A
enc_b  output  1  quadrature B
busy  output  1  move in progress
done  output  1  one-cycle pulse, move completed
aborted  output  1  one-cycle pulse, move aborted
position  output  POS_W  signed edge count

Behaviour:
- States: IDLE, RUN. All outputs registered.
- Reset (reset low, async): state IDLE; position=0; enc_a=0; enc_b=0; busy=0; done=0; aborted=0; cmd_ready=1.
- Output encoding from position[1:0], so A/B always match position:
  - enc_a = p1^p0, enc_b = p1.
  - Sequence 00 -> A1B0 -> A1B1 -> A0B1 -> 00.
  - Forward increments position; reverse decrements. Position wraps two's complement at POS_W.
- Accept: cmd_valid && cmd_ready at clock edge T0.
  - Latch steps, dir, and P = max(cmd_period, 1).
  - steps==0: stay IDLE, done=1 for the cycle after T0, no edges.
  - Else: enter RUN, busy=1, timer loaded.
- RUN:
  - Edge k (k=1..N) is registered at clock edge T0 + k*P. Each edge is exactly one position step.
  - At edge N, return to IDLE in the same clock edge: done=1, busy=0, cmd_ready=1 for the following cycle.
  - Back-to-back commands: a command presented with cmd_valid during the done cycle is accepted. The next move starts at its own T0.
- cmd_abort sampled high in RUN with no edge due that cycle: go to IDLE next edge, aborted=1 for one cycle, done=0, no further edges. Position keeps edges already emitted.
- cmd_abort on the same cycle as a scheduled edge: the edge is emitted first.
  - If it was edge N: done=1, aborted=0.
  - Otherwise: edge emitted, then IDLE with aborted=1.
- cmd_abort in IDLE: ignored.
- pos_clear in IDLE: position=0 next edge, enc_a=enc_b=0.
- pos_clear in RUN: ignored.
- pos_clear together with an accepted command: clear applies first, so the move starts from 0.
- cmd_* inputs are ignored while cmd_ready=0.
- Reset asserted mid-move: immediate return to reset values. Any pending edges are discarded.
- done and aborted are never high together. Each is exactly one cycle.

Optional Feature:
QUAD_ENC_GEN_INDEX_EN
- Defined: adds output port enc_z (1 bit, reset 0), registered, high while position[INDEX_LOG2-1:0]==0. It tracks position on the same clock edge as A/B, giving one index pulse per 2^INDEX_LOG2 counts in either direction.
- Undefined: enc_z port and logic are absent; INDEX_LOG2 is unused.

Test Plan:
- Forward move: steps=4, dir=1, period=3 accepted at T0 -> A/B = 10,11,01,00 at T0+3,+6,+9,+12; position 0->4; done pulse after T0+12; busy high for 12 cycles.
- Reverse move with wrap: from position 0, steps=2, dir=0, period=0 -> edges at T0+1, T0+2; A/B 01 then 11; position = 0xFFFFFE; done one cycle.
- Zero-step and back-to-back: steps=0 -> done next cycle, no A/B change. Then cmd_valid held during a done cycle with steps=1 -> accepted immediately, one edge after P cycles.
- Abort: steps=10, period=4, cmd_abort at T0+9 -> only edges at T0+4 and T0+8; aborted=1 one cycle, done=0, position=2. Abort coinciding with edge N -> done=1, aborted=0.
- Reset mid-move: reset low during RUN of steps=8 after 3 edges -> enc_a=enc_b=0, position=0, busy=0 asynchronously. After release, cmd_ready=1 and no stray edges.
- Index (QUAD_ENC_GEN_INDEX_EN, INDEX_LOG2=2): steps=8 forward from 0 -> enc_z high at position 0, 4, 8, low at other positions. pos_clear in IDLE at position 5 -> position 0, enc_z=1.
